// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control tokens, data-symbol decode and token lookup.
package tmds_pkg;

    localparam logic [9:0] TokenCtrl00 = 10'b1101010100;
    localparam logic [9:0] TokenCtrl01 = 10'b0010101011;
    localparam logic [9:0] TokenCtrl10 = 10'b0101010100;
    localparam logic [9:0] TokenCtrl11 = 10'b1010101011;

    typedef enum logic [0:0] {
        StSearch,
        StLocked
    } align_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] ctrl;
    } token_hit_t;

    // Undo the transmitter's optional inversion (bit 9) and XOR/XNOR chain (bit 8).
    function automatic logic [7:0] tmds_decode_symbol(input logic [9:0] word);
        logic [7:0] d;
        logic [7:0] q;
        d    = word[9] ? ~word[7:0] : word[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    function automatic token_hit_t tmds_token_lookup(input logic [9:0] word);
        token_hit_t t;
        t.hit  = 1'b1;
        t.ctrl = 2'b00;
        case (word)
            TokenCtrl00: t.ctrl = 2'b00;
            TokenCtrl01: t.ctrl = 2'b01;
            TokenCtrl10: t.ctrl = 2'b10;
            TokenCtrl11: t.ctrl = 2'b11;
            default:     t.hit  = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word aligner: holds the previous raw word and picks a 10-bit window at the current bit offset.
module tmds_word_align (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] raw_in,
    input  logic       raw_valid,
    input  logic       slip,
    output logic [9:0] word,
    output logic [3:0] offset
);

    logic [9:0]  prev_q;
    logic [3:0]  offset_q;
    logic [3:0]  offset_d;
    logic [19:0] window;

    // Older word sits in the low half since bit 0 is earliest on the wire.
    assign window = {raw_in, prev_q};

    always_comb begin
        word = 10'(window >> offset_q);
    end

    always_comb begin
        offset_d = offset_q;
        if (raw_valid && slip) begin
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            offset_q <= '0;
        end else begin
            if (raw_valid) begin
                prev_q <= raw_in;
            end
            offset_q <= offset_d;
        end
    end

    assign offset = offset_q;

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds the symbol boundary from control tokens, then decodes
// each symbol into video data, control bits and DE.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_TOKENS   = 16,
    parameter int unsigned SEARCH_WINDOW = 2048,
    parameter int unsigned LOSS_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] raw_in,
    input  logic       raw_valid,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int unsigned IdleMax = (SEARCH_WINDOW > LOSS_TIMEOUT) ? SEARCH_WINDOW
                                                                      : LOSS_TIMEOUT;
    localparam int unsigned RunW    = $clog2(LOCK_TOKENS) + 1;
    localparam int unsigned IdleW   = $clog2(IdleMax) + 1;
    localparam logic [RunW-1:0]  RunLast = RunW'(LOCK_TOKENS - 1);
    localparam logic [IdleW-1:0] SlipAt  = IdleW'(SEARCH_WINDOW - 1);
    localparam logic [IdleW-1:0] LossAt  = IdleW'(LOSS_TIMEOUT - 1);

    logic [9:0]   word;
    logic         slip;
    logic [9:0]   stage1_q;
    token_hit_t   tok;
    align_state_e state_q, state_d;
    logic [RunW-1:0]  run_q, run_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [1:0]   flush_q, flush_d;
    logic [7:0]   data_q, data_d;
    logic [1:0]   ctrl_q, ctrl_d;
    logic         de_q, de_d;

    tmds_word_align u_align (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .raw_valid (raw_valid),
        .slip      (slip),
        .word      (word),
        .offset    (offset)
    );

    assign tok = tmds_token_lookup(stage1_q);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        idle_d  = idle_q;
        flush_d = flush_q;
        slip    = 1'b0;
        if (raw_valid) begin
            if (flush_q != 2'd0) begin
                // Words straddling a slip were windowed at the old offset.
                flush_d = flush_q - 2'd1;
            end else begin
                unique case (state_q)
                    StSearch: begin
                        run_d  = tok.hit ? run_q + 1'b1 : '0;
                        idle_d = tok.hit ? '0 : idle_q + 1'b1;
                        if (tok.hit && run_q == RunLast) begin
                            state_d = StLocked;
                            run_d   = '0;
                            idle_d  = '0;
                        end else if (idle_d == SlipAt) begin
                            slip    = 1'b1;
                            run_d   = '0;
                            idle_d  = '0;
                            flush_d = 2'd2;
                        end
                    end
                    StLocked: begin
                        idle_d = tok.hit ? '0 : idle_q + 1'b1;
                        if (idle_d == LossAt) begin
                            state_d = StSearch;
                            run_d   = '0;
                            idle_d  = '0;
                        end
                    end
                    default: state_d = StSearch;
                endcase
            end
        end
    end

    // Gate on the next lock state so de_out/data_out drop in the same cycle as locked.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        de_d   = de_q;
        if (raw_valid) begin
            if (tok.hit) begin
                data_d = '0;
                ctrl_d = tok.ctrl;
                de_d   = 1'b0;
            end else if (state_d == StLocked) begin
                data_d = tmds_decode_symbol(stage1_q);
                de_d   = 1'b1;
            end else begin
                data_d = '0;
                de_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage1_q <= '0;
            state_q  <= StSearch;
            run_q    <= '0;
            idle_q   <= '0;
            flush_q  <= '0;
            data_q   <= '0;
            ctrl_q   <= '0;
            de_q     <= 1'b0;
        end else begin
            if (raw_valid) begin
                stage1_q <= word;
            end
            state_q <= state_d;
            run_q   <= run_d;
            idle_q  <= idle_d;
            flush_q <= flush_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            de_q    <= de_d;
        end
    end

    assign data_out = data_q;
    assign ctrl_out = ctrl_q;
    assign de_out   = de_q;
    assign locked   = (state_q == StLocked);

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: a 7-bit-shifted symbol stream, lock, decode,
// loss of lock, offset wrap, reset mid-lock and raw_valid flow control.
module tb_tmds_channel_decoder;

    localparam logic [9:0]  Tok         = 10'b1101010100;
    localparam logic [9:0]  Dat         = 10'h100;
    localparam int          LossTimeout = 4096;
    localparam int          LockBound   = 10 * 2048 + 16;
    // Raw words carry {S[n+1][6:0], S[n][9:7]}, so symbols start at bit 3 of {raw_in, prev}.
    localparam logic [3:0]  AlignOff    = 4'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] raw_in;
    logic       raw_valid;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       locked;
    logic [3:0] offset;

    int checks = 0;
    int errors = 0;
    logic [9:0] cur_sym = Tok;
    int line_pos = 0;

    logic [9:0] vec_sym  [8] = '{10'h2AB, 10'h0AB, 10'h100, 10'h200,
                                 10'h1AA, 10'h3C3, 10'h154, 10'h354};
    logic [7:0] exp_data [8] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'h44, 8'h00, 8'h00};
    logic [1:0] exp_ctrl [8] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    logic       exp_de   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    tmds_channel_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .raw_valid (raw_valid),
        .data_out  (data_out),
        .ctrl_out  (ctrl_out),
        .de_out    (de_out),
        .locked    (locked),
        .offset    (offset)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the raw word that completes cur_sym and starts sym; sample 1 time unit after the edge.
    task automatic send(input logic [9:0] sym, input logic v);
        raw_in    = {sym[6:0], cur_sym[9:7]};
        raw_valid = v;
        @(posedge clk);
        #1;
        if (v) cur_sym = sym;
    endtask

    function automatic logic [9:0] line_sym(input int p);
        return (p < 1280) ? Dat : Tok;
    endfunction

    task automatic stream_until_lock(input bit toggle);
        int nvalid;
        int cyc;
        logic v;
        nvalid = 0;
        cyc    = 0;
        while (!locked && nvalid < LockBound) begin
            v = toggle ? (cyc % 2 == 1) : 1'b1;
            send(line_sym(line_pos), v);
            if (v) begin
                nvalid++;
                line_pos = (line_pos == 1649) ? 0 : line_pos + 1;
            end
            cyc++;
        end
    endtask

    task automatic run_vectors(input bit gap);
        for (int i = 0; i < 10; i++) begin
            send((i < 8) ? vec_sym[i] : Tok, 1'b1);
            if (gap) send(Dat, 1'b0);
            if (i >= 2) begin
                check($sformatf("vec%0d data", i - 2), data_out, exp_data[i-2]);
                check($sformatf("vec%0d ctrl", i - 2), ctrl_out, exp_ctrl[i-2]);
                check($sformatf("vec%0d de", i - 2), de_out, exp_de[i-2]);
            end
        end
    endtask

    initial begin
        int   n;
        int   t_first;
        int   t_second;
        logic [3:0] last_off;

        reset     = 1'b0;
        raw_in    = '0;
        raw_valid = 1'b0;
        #22;
        check("reset data", data_out, 8'h00);
        check("reset ctrl", ctrl_out, 2'b00);
        check("reset de", de_out, 1'b0);
        check("reset locked", locked, 1'b0);
        check("reset offset", offset, 4'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        stream_until_lock(1'b0);
        check("first lock", locked, 1'b1);
        check("first lock offset", offset, AlignOff);

        run_vectors(1'b0);

        // Only data after the last token: locked holds LossTimeout sends, drops on the next.
        for (int i = 1; i <= LossTimeout; i++) send(Dat, 1'b1);
        check("lock held before timeout", locked, 1'b1);
        send(Dat, 1'b1);
        check("lock dropped at timeout", locked, 1'b0);
        check("offset kept on loss", offset, AlignOff);
        send(Dat, 1'b1);
        send(Dat, 1'b1);
        check("de after loss", de_out, 1'b0);
        check("data after loss", data_out, 8'h00);

        // No tokens at all: offset slips 3 -> 4 -> ... -> 9 -> 0.
        n        = 0;
        t_first  = -1;
        t_second = -1;
        last_off = offset;
        while (offset != 4'd0 && n < 16000) begin
            last_off = offset;
            send(Dat, 1'b1);
            n++;
            if (last_off == 4'd3 && offset == 4'd4) t_first = n;
            if (last_off == 4'd4 && offset == 4'd5) t_second = n;
        end
        check("wrap to zero", offset, 4'd0);
        check("offset before wrap", last_off, 4'd9);
        check("first slip time", t_first, 2045);
        check("slip period", t_second - t_first, 2049);
        check("unlocked while slipping", locked, 1'b0);

        stream_until_lock(1'b0);
        check("relock", locked, 1'b1);
        check("relock offset", offset, AlignOff);

        send(10'h2AB, 1'b1);
        send(Tok, 1'b1);
        send(Tok, 1'b1);
        check("ctrl before reset", ctrl_out, 2'b11);

        reset = 1'b0;
        #1;
        check("midreset locked", locked, 1'b0);
        check("midreset offset", offset, 4'd0);
        check("midreset ctrl", ctrl_out, 2'b00);
        check("midreset de", de_out, 1'b0);
        check("midreset data", data_out, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;

        stream_until_lock(1'b1);
        check("toggled lock", locked, 1'b1);
        check("toggled lock offset", offset, AlignOff);

        run_vectors(1'b1);

        // raw_valid low longer than the loss timeout must not advance the idle counter.
        for (int i = 0; i < LossTimeout + 100; i++) send(Dat, 1'b0);
        check("frozen lock", locked, 1'b1);
        check("frozen offset", offset, AlignOff);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
